// File: rtl/oled_text_streamer.sv
// Feeds the OLED controller: keeps a 4x16 ASCII text buffer and streams every cell
// over the controller's character-write handshake, followed by an optional display update.
module oled_text_streamer #(
   parameter logic [7:0] BLANK_CHAR = 8'h20,
   parameter bit         UPDATE_EN  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic [7:0] char_data,
   input  logic [1:0] char_row,
   input  logic [3:0] char_col,
   input  logic       refresh_req,
   input  logic       clear_req,
   output logic       write_start,
   output logic [7:0] write_ascii_data,
   output logic [8:0] write_base_addr,
   input  logic       write_ready,
   output logic       update_start,
   input  logic       update_ready,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [3:0] {
      CLEAR,
      IDLE,
      WR_ISSUE,
      WR_ACK,
      WR_WAIT,
      UPD_ISSUE,
      UPD_ACK,
      UPD_WAIT,
      DONE
   } state_t;

   state_t     state;
   logic [5:0] cell_cnt;
   logic       dirty;
   logic       clear_pend;
   logic [7:0] text_mem [64];
   logic       host_wr;
   logic [7:0] cur_char;

   assign char_ready = (state != CLEAR);
   assign busy       = (state != IDLE);
   assign host_wr    = char_valid && char_ready;
   assign cur_char   = text_mem[cell_cnt];

   // The buffer needs no reset: the CLEAR sweep that follows reset re-blanks every cell.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         text_mem[cell_cnt] <= BLANK_CHAR;
      end else if (host_wr) begin
         text_mem[{char_row, char_col}] <= char_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= CLEAR;
         cell_cnt         <= 6'd0;
         dirty            <= 1'b1;
         clear_pend       <= 1'b0;
         write_start      <= 1'b0;
         update_start     <= 1'b0;
         frame_done       <= 1'b0;
         write_ascii_data <= 8'h00;
         write_base_addr  <= 9'h000;
      end else begin
         write_start  <= 1'b0;
         update_start <= 1'b0;
         frame_done   <= 1'b0;
         case (state)
            CLEAR: begin
               if (cell_cnt == 6'd63) begin
                  cell_cnt   <= 6'd0;
                  dirty      <= 1'b1;
                  clear_pend <= 1'b0;
                  state      <= IDLE;
               end else begin
                  cell_cnt <= cell_cnt + 6'd1;
               end
            end
            IDLE: begin
               if (clear_pend) begin
                  cell_cnt <= 6'd0;
                  state    <= CLEAR;
               end else if (dirty || refresh_req) begin
                  dirty    <= 1'b0;
                  cell_cnt <= 6'd0;
                  state    <= WR_ISSUE;
               end
            end
            WR_ISSUE: begin
               if (write_ready) begin
                  write_start      <= 1'b1;
                  write_ascii_data <= cur_char;
                  write_base_addr  <= {cell_cnt, 3'b000};
                  state            <= WR_ACK;
               end
            end
            WR_ACK: begin
               if (!write_ready) state <= WR_WAIT;
            end
            WR_WAIT: begin
               if (write_ready) begin
                  if (cell_cnt == 6'd63) begin
                     if (UPDATE_EN) begin
                        state <= UPD_ISSUE;
                     end else begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                     end
                  end else begin
                     cell_cnt <= cell_cnt + 6'd1;
                     state    <= WR_ISSUE;
                  end
               end
            end
            UPD_ISSUE: begin
               if (update_ready) begin
                  update_start <= 1'b1;
                  state        <= UPD_ACK;
               end
            end
            UPD_ACK: begin
               if (!update_ready) state <= UPD_WAIT;
            end
            UPD_WAIT: begin
               if (update_ready) begin
                  frame_done <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= CLEAR;
            end
         endcase
         // A host write always re-marks the buffer, even one accepted while a frame starts.
         if (host_wr) dirty <= 1'b1;
         if (clear_req && (state != CLEAR)) clear_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_oled_text_streamer.sv
// Bench for oled_text_streamer: randomised OLED controller timing, a text-buffer
// reference model and frame capture, plus a second instance built with UPDATE_EN=0.
module tb_oled_text_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rst_b;
   logic       char_valid, refresh_req, clear_req, refresh_b;
   logic [7:0] char_data;
   logic [1:0] char_row;
   logic [3:0] char_col;
   logic       char_ready, write_start, update_start, busy, frame_done;
   logic [7:0] write_ascii_data;
   logic [8:0] write_base_addr;
   logic       write_ready, update_ready;
   logic       char_ready_b, write_start_b, update_start_b, busy_b, frame_done_b;
   logic [7:0] write_ascii_data_b;
   logic [8:0] write_base_addr_b;
   logic       write_ready_b;
   logic       hold_wr;

   int tests = 0;
   int fails = 0;

   logic [7:0] ref_buf [64];
   logic [7:0] snap [64];
   logic [7:0] blank_img [64];

   oled_text_streamer #(.BLANK_CHAR(8'h20), .UPDATE_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
      .char_row(char_row), .char_col(char_col),
      .refresh_req(refresh_req), .clear_req(clear_req),
      .write_start(write_start), .write_ascii_data(write_ascii_data),
      .write_base_addr(write_base_addr), .write_ready(write_ready),
      .update_start(update_start), .update_ready(update_ready),
      .busy(busy), .frame_done(frame_done)
   );

   oled_text_streamer #(.BLANK_CHAR(8'h20), .UPDATE_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst_b),
      .char_valid(1'b0), .char_ready(char_ready_b), .char_data(8'h00),
      .char_row(2'd0), .char_col(4'd0),
      .refresh_req(refresh_b), .clear_req(1'b0),
      .write_start(write_start_b), .write_ascii_data(write_ascii_data_b),
      .write_base_addr(write_base_addr_b), .write_ready(write_ready_b),
      .update_start(update_start_b), .update_ready(1'b1),
      .busy(busy_b), .frame_done(frame_done_b)
   );

   // Controller model: after each start, ready stays high 0..5 cycles, then low 1..4 cycles.
   int wt = 0, wl = 0, ut = 0, ul = 0;
   always @(posedge clk) begin
      int l;
      if (write_start) begin
         l = $urandom_range(4, 1);
         wl <= l;
         wt <= l + $urandom_range(5, 0);
      end else if (wt > 0) begin
         wt <= wt - 1;
      end
      if (update_start) begin
         l = $urandom_range(4, 1);
         ul <= l;
         ut <= l + $urandom_range(5, 0);
      end else if (ut > 0) begin
         ut <= ut - 1;
      end
   end
   assign write_ready  = !hold_wr && !((wt > 0) && (wt <= wl));
   assign update_ready = !((ut > 0) && (ut <= ul));

   int wtb = 0;
   always @(posedge clk) begin
      if (write_start_b) wtb <= 3;
      else if (wtb > 0) wtb <= wtb - 1;
   end
   assign write_ready_b = !((wtb > 0) && (wtb <= 2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame capture for the main instance.
   logic [7:0] cap_d [64], last_d [64];
   logic [8:0] cap_a [64], last_a [64];
   int wcnt = 0, ucnt = 0, last_w = 0, last_u = 0, frames = 0, total_ws = 0, total_us = 0;
   logic prev_ws = 1'b0, prev_us = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         wcnt = 0;
         ucnt = 0;
      end else begin
         if (write_start) begin
            check("write_start_isolated", {29'd0, prev_ws, prev_us, update_start}, 32'd0);
            if (wcnt < 64) begin
               cap_d[wcnt] = write_ascii_data;
               cap_a[wcnt] = write_base_addr;
            end
            wcnt++;
            total_ws++;
         end
         if (update_start) begin
            check("update_start_isolated", {30'd0, prev_ws, prev_us}, 32'd0);
            ucnt++;
            total_us++;
         end
         if (frame_done) begin
            last_d = cap_d;
            last_a = cap_a;
            last_w = wcnt;
            last_u = ucnt;
            wcnt   = 0;
            ucnt   = 0;
            frames++;
         end
      end
      prev_ws = write_start;
      prev_us = update_start;
   end

   int wb = 0, ub = 0, eb = 0, last_wb = 0, last_ub = 0, last_eb = 0, frames_b = 0;
   always @(negedge clk) begin
      if (rst_b) begin
         wb = 0; ub = 0; eb = 0;
      end else begin
         if (write_start_b) begin
            if (write_base_addr_b !== 9'(wb * 8) || write_ascii_data_b !== 8'h20) eb++;
            wb++;
         end
         if (update_start_b) ub++;
         if (frame_done_b) begin
            last_wb = wb; last_ub = ub; last_eb = eb;
            wb = 0; ub = 0; eb = 0;
            frames_b++;
         end
      end
   end

   task automatic check_frame(input string tag, input int exp_u, input logic [7:0] exp_img [64]);
      int bad = -1;
      check({tag, "_writes"}, last_w, 64);
      check({tag, "_updates"}, exp_u, last_u);
      for (int i = 0; i < 64; i++)
         if (bad < 0 && (last_a[i] !== 9'(i * 8) || last_d[i] !== exp_img[i])) bad = i;
      check({tag, "_first_bad_cell"}, bad, -1);
   endtask

   task automatic wait_frame(input string tag);
      int f0 = frames;
      int n  = 0;
      while (frames == f0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_frame_done_seen"}, {31'd0, frames != f0}, 32'd1);
   endtask

   // Waits out the frame in flight plus any follow-up frames queued by dirty writes.
   task automatic settle(input string tag);
      int k = 0;
      wait_frame(tag);
      repeat (2) @(negedge clk);
      while (busy && k < 3) begin
         wait_frame(tag);
         repeat (2) @(negedge clk);
         k++;
      end
      check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic host_write(input logic [1:0] row, input logic [3:0] col, input logic [7:0] data);
      int n = 0;
      @(negedge clk);
      char_valid = 1'b1;
      char_row   = row;
      char_col   = col;
      char_data  = data;
      while (!char_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("host_accept", {31'd0, char_ready}, 32'd1);
      @(negedge clk);
      char_valid = 1'b0;
      ref_buf[{row, col}] = data;
   endtask

   task automatic pulse_refresh();
      @(negedge clk); refresh_req = 1'b1;
      @(negedge clk); refresh_req = 1'b0;
   endtask

   task automatic count_clear(input string tag);
      int n = 0;
      while (!char_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check(tag, n, 64);
   endtask

   task automatic wait_cells(input int target);
      int n = 0;
      while (wcnt < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_write_index", {31'd0, wcnt >= target}, 32'd1);
   endtask

   initial begin : applyStimulus
      int f0, s0, u0, n;
      logic [1:0] r;
      logic [3:0] c;
      rst = 1'b1; rst_b = 1'b1; hold_wr = 1'b0;
      char_valid = 1'b0; char_data = 8'h00; char_row = 2'd0; char_col = 4'd0;
      refresh_req = 1'b0; clear_req = 1'b0; refresh_b = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ref_buf[i]   = 8'h20;
         blank_img[i] = 8'h20;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_write_start", {31'd0, write_start}, 32'd0);
      check("rst_update_start", {31'd0, update_start}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_ascii_data", {24'd0, write_ascii_data}, 32'd0);
      check("rst_base_addr", {23'd0, write_base_addr}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_char_ready", {31'd0, char_ready}, 32'd0);
      rst = 1'b0; rst_b = 1'b0;
      count_clear("boot_clear_cycles");
      settle("boot");
      check_frame("boot", 1, blank_img);

      f0 = frames;
      host_write(2'd2, 4'd5, 8'h41);
      settle("char_a");
      check("char_a_frame_count", frames - f0, 1);
      check_frame("char_a", 1, ref_buf);
      check("char_a_cell_0x128", {15'd0, last_a[37], last_d[37]}, {15'd0, 9'h128, 8'h41});

      snap = ref_buf;
      f0 = frames;
      pulse_refresh();
      wait_cells(10);
      host_write(2'd0, 4'd0, 8'h5A);
      wait_frame("z_first");
      check_frame("z_first", 1, snap);
      settle("z_second");
      check_frame("z_second", 1, ref_buf);
      check("z_frame_count", frames - f0, 2);

      for (int it = 0; it < 4; it++) begin
         int k = $urandom_range(4, 1);
         for (int j = 0; j < k; j++) begin
            r = 2'($urandom_range(3, 0));
            c = 4'($urandom_range(15, 0));
            if (it == 0 && j == 0) begin
               r = 2'd3;
               c = 4'd15;
            end
            host_write(r, c, 8'($urandom_range(8'h7E, 8'h21)));
         end
         settle("rand");
         check_frame("rand", 1, ref_buf);
      end

      hold_wr = 1'b1;
      pulse_refresh();
      s0 = total_ws;
      repeat (200) @(negedge clk);
      check("hold_no_start", total_ws - s0, 0);
      check("hold_busy", {31'd0, busy}, 32'd1);
      hold_wr = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_one_start", total_ws - s0, 1);
      settle("hold");
      check_frame("hold", 1, ref_buf);

      n = 0;
      while (busy_b && n < 3000) begin
         @(negedge clk);
         n++;
      end
      f0 = frames_b;
      @(negedge clk); refresh_b = 1'b1;
      @(negedge clk); refresh_b = 1'b0;
      n = 0;
      while (frames_b == f0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("noupd_frame_done", {31'd0, frames_b != f0}, 32'd1);
      check("noupd_writes", last_wb, 64);
      check("noupd_updates", last_ub, 0);
      check("noupd_bad_cells", last_eb, 0);

      @(negedge clk); clear_req = 1'b1;
      @(negedge clk); clear_req = 1'b0;
      n = 0;
      while (char_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      count_clear("idle_clear_cycles");
      ref_buf = blank_img;
      settle("idle_clear");
      check_frame("idle_clear", 1, ref_buf);

      host_write(2'd1, 4'd3, 8'h51);
      host_write(2'd3, 4'd0, 8'h52);
      settle("preset");
      check_frame("preset", 1, ref_buf);
      pulse_refresh();
      wait_cells(5);
      @(negedge clk); clear_req = 1'b1;
      @(negedge clk); clear_req = 1'b0;
      wait_cells(30);
      @(negedge clk); rst = 1'b1;
      @(posedge clk);
      #1;
      s0 = total_ws;
      u0 = total_us;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      count_clear("rst_clear_cycles");
      check("rst_no_write_start", total_ws - s0, 0);
      check("rst_no_update_start", total_us - u0, 0);
      ref_buf = blank_img;
      settle("post_rst");
      check_frame("post_rst", 1, ref_buf);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
